div_seq: RTL and testbench



---
 rtl/div_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_div_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : iterative RV32M divide unit (DIV, DIVU, REM, REMU)
//
// One ripple-carry adder is time-shared for every arithmetic step: operand
// negation, one restoring-division step per cycle, and the final sign fix-up.
// The unit sits beside the execute stage; the hazard logic stalls the
// pipeline for as long as busy is high.
//
// Ports
//   clk     in   1      clock, all state changes on the rising edge
//   rst     in   1      synchronous active-high reset
//   start   in   1      operation request, taken only when not busy
//                       (or in the done cycle, for back-to-back issue)
//   op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a       in   WIDTH  dividend, sampled on the accept edge
//   b       in   WIDTH  divisor, sampled on the accept edge
//   busy    out  1      high from the cycle after accept through done
//   done    out  1      one-cycle pulse, result valid in that cycle
//   result  out  WIDTH  quotient or remainder, held until next accept
//
// WIDTH must be at least 4 and 2**CNT_W must exceed WIDTH.
// ---------------------------------------------------------------------------

// Ripple-carry adder. With subEn set it computes a - b as a + ~b + 1, and
// cout then reports a >= b when both are read as unsigned numbers.
module Rca #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subEn,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] bInv;

  assign bInv     = b ^ {WIDTH{subEn}};
  assign carry[0] = subEn;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ bInv[i] ^ carry[i];
    assign carry[i+1] = (a[i] & bInv[i]) | (a[i] & carry[i]) | (bInv[i] & carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule

module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             negQ_q;
  logic             negR_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] addA;
  logic [WIDTH-1:0] addB;
  logic             addSub;
  logic [WIDTH-1:0] addSum;
  logic             addCout;

  logic [WIDTH-1:0] shifted;
  logic             take;
  logic [WIDTH-1:0] fixVal;
  logic             fixNeg;

  logic             acceptNow;
  logic             inSigned;
  logic             inDivZero;
  logic             inOverflow;

  Rca #(.WIDTH(WIDTH)) u_rca (
    .a     (addA),
    .b     (addB),
    .subEn (addSub),
    .sum   (addSum),
    .cout  (addCout)
  );

  // Decode of the incoming request. A new operation may be taken from IDLE
  // or on the edge that leaves DONE, so back-to-back issue loses no cycle.
  // The two special cases (divide by zero, most-negative / -1) finish
  // straight away without touching the adder.
  always_comb begin
    acceptNow  = start & ((state_q == IDLE) | (state_q == DONE));
    inSigned   = ~op[0];
    inDivZero  = (b == '0);
    inOverflow = inSigned & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
  end

  // Restoring-division step. The remainder shifts left taking the next
  // dividend bit from the top of the quotient register. If the shifted-out
  // remainder MSB was set, the partial remainder is at least 2**WIDTH and
  // therefore certainly not smaller than the divisor, so the subtract is
  // taken even though cout alone would not show it.
  always_comb begin
    shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    take    = rem_q[WIDTH-1] | addCout;
    fixVal  = op_q[1] ? rem_q : quo_q;
    fixNeg  = op_q[1] ? negR_q : negQ_q;
  end

  // Adder input steering. Every use is a subtraction: negation is 0 - x,
  // and the division step is shifted - divisor. IDLE and DONE leave the
  // adder idle with zero inputs.
  always_comb begin
    addA   = '0;
    addB   = '0;
    addSub = 1'b1;
    case (state_q)
      NEG_A: addB = quo_q;
      NEG_B: addB = dvs_q;
      ITER: begin
        addA = shifted;
        addB = dvs_q;
      end
      FIX:   addB = fixVal;
      default: begin
        addA = '0;
        addB = '0;
      end
    endcase
  end

  // Main sequencer. Reset wins over everything, so an operation in flight
  // is simply dropped and never raises done. The dividend register is
  // reused as the quotient: each iteration shifts one dividend bit out of
  // the top and one quotient bit in at the bottom. Negation flags are
  // computed from the raw operands at accept time because the operand
  // registers are overwritten with magnitudes afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (acceptNow) begin
      quo_q  <= a;
      dvs_q  <= b;
      op_q   <= op;
      negQ_q <= inSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
      negR_q <= inSigned & a[WIDTH-1];
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      if (inDivZero) begin
        result_q <= op[1] ? a : '1;
        state_q  <= DONE;
        done_q   <= 1'b1;
      end else if (inOverflow) begin
        result_q <= op[1] ? '0 : a;
        state_q  <= DONE;
        done_q   <= 1'b1;
      end else begin
        state_q <= NEG_A;
        done_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        NEG_A: begin
          if (negR_q) quo_q <= addSum;
          state_q <= NEG_B;
        end
        NEG_B: begin
          if (~op_q[0] & dvs_q[WIDTH-1]) dvs_q <= addSum;
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= ITER;
        end
        ITER: begin
          rem_q <= take ? addSum : shifted;
          quo_q <= {quo_q[WIDTH-2:0], take};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= fixNeg ? addSum : fixVal;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq : self-checking bench for div_seq
//
// Directed steps cover the quoted arithmetic cases, the special cases with
// their short latency, ignored start while busy, reset abort and back-to-back
// issue. A randomized section compares against a plain-arithmetic model of
// the RV32M division rules.
// ---------------------------------------------------------------------------
module tb_div_seq;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: RV32M results straight from the ISA rules, using the
  // simulator's own signed and unsigned division.
  function automatic logic [W-1:0] refModel(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic signed [W-1:0] sx;
    logic signed [W-1:0] sy;
    logic signed [W-1:0] sr;
    logic                ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'b00: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        sr = sx / sy;
        return sr;
      end
      2'b01: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      2'b10: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        sr = sx % sy;
        return sr;
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [1:0] o, input logic [W-1:0] x,
                                    input logic [W-1:0] y);
    if (y == 0) return 0;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return LAT;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents a request, lets the accept edge pass, then
  // scrambles the inputs so late changes would be noticed.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Starts at the negedge after accept (cycle 0) and stops at the negedge
  // of the done cycle. pokeAt >= 0 raises a stray start at that cycle.
  task automatic waitDone(input string tag, input logic [W-1:0] exp, input int expLat,
                          input int pokeAt);
    int   k;
    logic busyOk;
    k      = 0;
    busyOk = 1'b1;
    while (done !== 1'b1 && k < 200) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (k == pokeAt) begin
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (busy !== 1'b1) busyOk = 1'b0;
    checkOutput($sformatf("%s done", tag), W'(done), W'(1));
    checkOutput($sformatf("%s latency", tag), W'(k), W'(expLat));
    checkOutput($sformatf("%s result", tag), result, exp);
    checkOutput($sformatf("%s busy", tag), W'(busyOk), W'(1));
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp, input int expLat,
                       input int pokeAt);
    @(negedge clk);
    applyStimulus(o, x, y);
    waitDone(tag, exp, expLat, pokeAt);
    @(negedge clk);
    checkOutput($sformatf("%s done low", tag), W'(done), W'(0));
    checkOutput($sformatf("%s busy low", tag), W'(busy), W'(0));
    checkOutput($sformatf("%s held", tag), result, exp);
  endtask

  initial begin
    logic         sawDone;
    logic [1:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", W'(busy), W'(0));
    checkOutput("reset done", W'(done), W'(0));
    checkOutput("reset result", result, '0);
    rst = 1'b0;

    $display("[TB] directed arithmetic");
    runOp("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, LAT, -1);
    runOp("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, LAT, -1);
    runOp("DIV -7/2", 2'b00, -32'd7, 32'd2, -32'd3, LAT, -1);
    runOp("REM -7/2", 2'b10, -32'd7, 32'd2, -32'd1, LAT, -1);
    runOp("DIV 7/-2", 2'b00, 32'd7, -32'd2, -32'd3, LAT, -1);
    runOp("REM -8/-3", 2'b10, -32'd8, -32'd3, -32'd2, LAT, -1);

    $display("[TB] special cases");
    runOp("DIVU 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, -1);
    runOp("DIV -5/0", 2'b00, -32'd5, 32'd0, 32'hFFFF_FFFF, 0, -1);
    runOp("REM 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 0, -1);
    runOp("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, -1);
    runOp("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, -1);

    $display("[TB] shift-out path");
    runOp("DIVU max/msb", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, LAT, -1);
    runOp("REMU max/msb", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, LAT, -1);
    runOp("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT, -1);

    $display("[TB] start while busy");
    runOp("poke DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, LAT, 10);

    $display("[TB] reset abort");
    @(negedge clk);
    applyStimulus(2'b01, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", W'(busy), W'(0));
    checkOutput("abort result", result, '0);
    checkOutput("abort done", W'(done), W'(0));
    sawDone = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort no done", W'(sawDone), W'(0));

    $display("[TB] back-to-back");
    @(negedge clk);
    applyStimulus(2'b01, 32'd100, 32'd7);
    waitDone("b2b first", 32'd14, LAT, -1);
    applyStimulus(2'b00, -32'd20, 32'd3);
    checkOutput("b2b done fell", W'(done), W'(0));
    waitDone("b2b second", -32'd6, LAT, -1);
    @(negedge clk);
    checkOutput("b2b idle", W'(busy), W'(0));

    $display("[TB] randomized");
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rx = (($urandom % 6) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom % 6)
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 15));
        2: ry = -32'($urandom_range(1, 15));
        3: ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      runOp($sformatf("rand%0d op%0d %h/%h", i, ro, rx, ry), ro, rx, ry,
            refModel(ro, rx, ry), refLatency(ro, rx, ry), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
